// File: rtl/c6288_seq_pkg.sv
// Shared types and constants for the c6288 aging-experiment vector sequencer.
// Vector memory words are {stimulus, golden}; the slice constants below locate each field.
package c6288_seq_pkg;

   localparam int VEC_WIDTH  = 32;
   localparam int RES_WIDTH  = 32;
   localparam int ADDR_WIDTH = 16;
   localparam int SETTLE_W   = 8;
   localparam int MEM_WIDTH  = VEC_WIDTH + RES_WIDTH;

   localparam int STIM_LSB = RES_WIDTH;
   localparam int GOLD_LSB = 0;

   // x^32 + x^22 + x^2 + x + 1, with the x^32 term implied by the shift-out bit
   localparam logic [31:0] MISR_POLY = 32'h0040_0007;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SETTLE,
      S_CAPTURE,
      S_DONE
   } state_t;

endpackage

// File: rtl/c6288_seq_misr.sv
// 32-bit multiple-input signature register that compacts captured multiplier products.
// Seed loads all-ones; shift folds one response word in per capture.
module c6288_seq_misr
   import c6288_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 seed,
   input  logic                 shift,
   input  logic [RES_WIDTH-1:0] data,
   output logic [RES_WIDTH-1:0] signature
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         signature <= '0;
      end else if (seed) begin
         signature <= '1;
      end else if (shift) begin
         signature <= {signature[RES_WIDTH-2:0], 1'b0}
                      ^ (signature[RES_WIDTH-1] ? MISR_POLY : '0)
                      ^ data;
      end
   end

endmodule

// File: rtl/c6288_vec_sequencer.sv
// Vector sequencer: fetch {stimulus, golden}, drive the c6288, settle, capture and compare.
// Define C6288_SEQ_MISR_EN to add a response signature output.
module c6288_vec_sequencer
   import c6288_seq_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] num_vec,
   input  logic [SETTLE_W-1:0]   settle_cycles,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [MEM_WIDTH-1:0]  mem_rdata,
   output logic [VEC_WIDTH-1:0]  dut_in,
   input  logic [RES_WIDTH-1:0]  dut_out,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] err_cnt,
   output logic                  first_err_valid,
   output logic [ADDR_WIDTH-1:0] first_err_idx,
   output logic [RES_WIDTH-1:0]  last_capture
`ifdef C6288_SEQ_MISR_EN
   ,
   output logic [RES_WIDTH-1:0]  signature
`endif
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] idx;
   logic [ADDR_WIDTH-1:0] num_vec_q;
   logic [SETTLE_W-1:0]   settle_q;
   logic [SETTLE_W-1:0]   settle_cnt;
   logic [RES_WIDTH-1:0]  exp_reg;
   logic                  start_ok;
   logic                  cap_en;

   assign start_ok = start && !abort && (state == S_IDLE || state == S_DONE);
   assign cap_en   = (state == S_CAPTURE) && !abort;

   // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         idx             <= '0;
         num_vec_q       <= '0;
         settle_q        <= '0;
         settle_cnt      <= '0;
         exp_reg         <= '0;
         mem_rd          <= 1'b0;
         mem_addr        <= '0;
         dut_in          <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_cnt         <= '0;
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
         last_capture    <= '0;
      end else begin
         mem_rd <= 1'b0;
         if (abort) begin
            if (busy) begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         end else if (start_ok) begin
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            idx             <= '0;
            num_vec_q       <= num_vec;
            settle_q        <= settle_cycles;
            if (num_vec == '0) begin
               state <= S_DONE;
               done  <= 1'b1;
               busy  <= 1'b0;
            end else begin
               state    <= S_FETCH;
               done     <= 1'b0;
               busy     <= 1'b1;
               mem_rd   <= 1'b1;
               mem_addr <= '0;
            end
         end else begin
            case (state)
               S_FETCH: state <= S_LOAD;
               S_LOAD: begin
                  dut_in     <= mem_rdata[STIM_LSB +: VEC_WIDTH];
                  exp_reg    <= mem_rdata[GOLD_LSB +: RES_WIDTH];
                  settle_cnt <= settle_q;
                  state      <= (settle_q == '0) ? S_CAPTURE : S_SETTLE;
               end
               S_SETTLE: begin
                  settle_cnt <= settle_cnt - 1'b1;
                  if (settle_cnt == SETTLE_W'(1)) state <= S_CAPTURE;
               end
               S_CAPTURE: begin
                  last_capture <= dut_out;
                  if (dut_out != exp_reg) begin
                     if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                     if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= idx;
                     end
                  end
                  // Compare against num_vec-1 so a full-range count never wraps idx
                  if (idx == num_vec_q - 1'b1) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     idx      <= idx + 1'b1;
                     mem_rd   <= 1'b1;
                     mem_addr <= idx + 1'b1;
                     state    <= S_FETCH;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef C6288_SEQ_MISR_EN
   c6288_seq_misr u_misr (
      .clk       (clk),
      .rst       (rst),
      .seed      (start_ok),
      .shift     (cap_en),
      .data      (dut_out),
      .signature (signature)
   );
`endif

endmodule

// File: tb/tb_c6288_vec_sequencer.sv
// Self-checking bench: behavioural vector memory and multiplier, directed plus random runs
// compared against a per-run reference computed from the vector tables.
module tb_c6288_vec_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] num_vec = '0;
   logic [7:0]  settle_cycles = '0;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [63:0] mem_rdata = '0;
   logic [31:0] dut_in;
   logic [31:0] dut_out;
   logic        busy, done, first_err_valid;
   logic [15:0] err_cnt, first_err_idx;
   logic [31:0] last_capture;
`ifdef C6288_SEQ_MISR_EN
   logic [31:0] signature;
`endif

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rd_addr_q[$];
   int          rd_cyc_q[$];
   logic [31:0] stim [64];
   logic [31:0] gold [64];
   logic        flip_en = 1'b0;
   logic [31:0] flip_stim = '0;
   logic [31:0] model_last = '0;

   always #5 clk = ~clk;

   c6288_vec_sequencer dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .abort           (abort),
      .num_vec         (num_vec),
      .settle_cycles   (settle_cycles),
      .mem_rd          (mem_rd),
      .mem_addr        (mem_addr),
      .mem_rdata       (mem_rdata),
      .dut_in          (dut_in),
      .dut_out         (dut_out),
      .busy            (busy),
      .done            (done),
      .err_cnt         (err_cnt),
      .first_err_valid (first_err_valid),
      .first_err_idx   (first_err_idx),
      .last_capture    (last_capture)
`ifdef C6288_SEQ_MISR_EN
      ,
      .signature       (signature)
`endif
   );

   // Upper half of the stimulus times the lower half, as the c6288 computes it
   function automatic logic [31:0] prod(input logic [31:0] s);
      int unsigned a, b;
      a = s >> 16;
      b = s & 32'h0000_FFFF;
      return a * b;
   endfunction

   function automatic logic [31:0] flip_of(input logic [31:0] s);
      return (flip_en && s == flip_stim) ? 32'h0000_0001 : 32'h0000_0000;
   endfunction

   assign dut_out = prod(dut_in) ^ flip_of(dut_in);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd) begin
         mem_rdata <= {stim[mem_addr[5:0]], gold[mem_addr[5:0]]};
         rd_addr_q.push_back(int'(mem_addr));
         rd_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "simulation watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_vec(input int i, input logic [31:0] s, input bit corrupt);
      stim[i] = s;
      gold[i] = prod(s) ^ (corrupt ? 32'h0000_0100 : 32'h0000_0000);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, "_dut_in"}, 64'(dut_in), 64'd0);
      check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
      check({tag, "_fev"}, 64'(first_err_valid), 64'd0);
      check({tag, "_fei"}, 64'(first_err_idx), 64'd0);
      check({tag, "_last"}, 64'(last_capture), 64'd0);
`ifdef C6288_SEQ_MISR_EN
      check({tag, "_sig"}, 64'(signature), 64'd0);
`endif
   endtask

   // Bounded wait for the read strobe of a given vector index
   task automatic wait_fetch(input string tag, input int a);
      int t = 0;
      while (!(mem_rd === 1'b1 && int'(mem_addr) == a) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_fetch_reach"}, 64'(t < 500), 64'd1);
   endtask

   task automatic begin_run(input int n, input int s);
      rd_addr_q.delete();
      rd_cyc_q.delete();
      @(negedge clk);
      num_vec = 16'(n);
      settle_cycles = 8'(s);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Full run checked against the reference; poke drives start while busy
   task automatic do_run(input string tag, input int n, input int s, input bit poke);
      int t, limit, exp_err, exp_first, bad_addr, bad_sp;
      bit exp_fv;
      logic [31:0] p, exp_last;
      exp_err = 0; exp_first = 0; exp_fv = 0; exp_last = model_last;
      for (int i = 0; i < n; i++) begin
         p = prod(stim[i]) ^ flip_of(stim[i]);
         if (p != gold[i]) begin
            exp_err++;
            if (!exp_fv) exp_first = i;
            exp_fv = 1;
         end
         exp_last = p;
      end
      begin_run(n, s);
      if (n > 0) begin
         check({tag, "_busy_at_start"}, 64'(busy), 64'd1);
         check({tag, "_err_cleared"}, 64'(err_cnt), 64'd0);
         check({tag, "_fev_cleared"}, 64'(first_err_valid), 64'd0);
      end
      t = 0;
      limit = n * (3 + s) + 50;
      while (!done && t < limit) begin
         start = poke && (t % 4 == 1);
         num_vec = poke ? 16'd7 : 16'(n);
         @(negedge clk);
         t++;
      end
      start = 1'b0;
      check({tag, "_cycles"}, 64'(t), 64'(n * (3 + s)));
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
      check({tag, "_fev"}, 64'(first_err_valid), 64'(exp_fv));
      if (exp_fv) check({tag, "_fei"}, 64'(first_err_idx), 64'(exp_first));
      if (n > 0) check({tag, "_last"}, 64'(last_capture), 64'(exp_last));
      check({tag, "_rd_count"}, 64'(rd_addr_q.size()), 64'(n));
      bad_addr = 0; bad_sp = 0;
      for (int i = 0; i < rd_addr_q.size(); i++) begin
         if (rd_addr_q[i] != i) bad_addr++;
         if (i > 0 && rd_cyc_q[i] - rd_cyc_q[i-1] != 3 + s) bad_sp++;
      end
      check({tag, "_addr_seq"}, 64'(bad_addr), 64'd0);
      check({tag, "_rd_spacing"}, 64'(bad_sp), 64'd0);
      model_last = exp_last;
   endtask

   initial begin
      logic [31:0] sig_a, sig_b, sig_c;
      int n, s;
      sig_a = '0; sig_b = '0; sig_c = '0;
      for (int i = 0; i < 64; i++) load_vec(i, 32'h0, 1'b0);

      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // Pass run from the published vectors
      load_vec(0, 32'h0003_0005, 1'b0);
      load_vec(1, 32'hFFFF_FFFF, 1'b0);
      load_vec(2, 32'h0000_0000, 1'b0);
      load_vec(3, 32'h8000_0002, 1'b0);
      do_run("pass", 4, 2, 1'b0);
      check("pass_last_const", 64'(last_capture), 64'h0001_0000);

`ifdef C6288_SEQ_MISR_EN
      sig_a = signature;
      do_run("misr_rep", 4, 2, 1'b0);
      sig_b = signature;
      check("misr_repeat", 64'(sig_b), 64'(sig_a));
      flip_en = 1'b1;
      flip_stim = 32'hFFFF_FFFF;
      do_run("misr_flip", 4, 2, 1'b0);
      sig_c = signature;
      flip_en = 1'b0;
      check("misr_flip_differs", 64'(sig_c != sig_a), 64'd1);
`endif

      // Golden corrupted at indices 1 and 2
      load_vec(0, 32'h1234_5678, 1'b0);
      load_vec(1, 32'h00FF_0101, 1'b1);
      load_vec(2, 32'hABCD_0003, 1'b1);
      do_run("err", 3, 1, 1'b0);
      check("err_cnt_const", 64'(err_cnt), 64'd2);
      check("err_fei_const", 64'(first_err_idx), 64'd1);

      do_run("zero", 0, 3, 1'b0);
      for (int i = 0; i < 5; i++) load_vec(i, $urandom, i == 4);
      do_run("settle0", 5, 0, 1'b0);

      // Abort during SETTLE of the fifth vector
      for (int i = 0; i < 10; i++) load_vec(i, $urandom, i == 2);
      begin_run(10, 4);
      wait_fetch("abort", 4);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_err_cnt", 64'(err_cnt), 64'd1);
      check("abort_fei", 64'(first_err_idx), 64'd2);
      repeat (5) @(negedge clk);
      check("abort_no_more_reads", 64'(rd_addr_q.size()), 64'd5);

      // Abort and start together in IDLE: abort wins
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_start_busy", 64'(busy), 64'd0);
      check("abort_start_reads", 64'(rd_addr_q.size()), 64'd5);
      do_run("after_abort", 10, 4, 1'b0);

      // Abort in CAPTURE of a corrupted vector drops the capture
      load_vec(0, 32'h0101_0202, 1'b1);
      begin_run(2, 0);
      wait_fetch("abort_cap", 0);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_cap_err", 64'(err_cnt), 64'd0);
      check("abort_cap_fev", 64'(first_err_valid), 64'd0);
      check("abort_cap_last", 64'(last_capture), 64'(model_last));

      // Start pulses while busy must not restart the run
      for (int i = 0; i < 4; i++) load_vec(i, $urandom, 1'b0);
      do_run("busy_start", 4, 1, 1'b1);

      // Reset asserted while in CAPTURE of vector 1
      for (int i = 0; i < 3; i++) load_vec(i, $urandom, i == 0);
      begin_run(3, 1);
      wait_fetch("rst_cap", 1);
      repeat (3) @(negedge clk);
      check("rst_cap_pre_err", 64'(err_cnt), 64'd1);
      rst = 1'b1;
      #1;
      check_reset_state("rst_cap");
      @(negedge clk);
      rst = 1'b0;
      model_last = '0;

      // Randomised runs
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 20);
         s = $urandom_range(0, 5);
         for (int i = 0; i < n; i++) load_vec(i, $urandom, $urandom_range(0, 3) == 0);
         do_run($sformatf("rand%0d", r), n, s, r == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
